// File: rtl/rv_byte_cpu.sv
// rv_byte_cpu: single-cycle RV32I-subset core. The program is streamed in one
// byte per clock (0xFE starts, 0xFF ends), then executed from internal imem.
// Registers and data memory are readable byte-wise through a combinational
// debug port.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset        synchronous active-high reset (clears regs, dmem, PC, flags)
//   instr_i      program byte stream, consumed only in IDLE/LOAD
//   DataOrReg    debug select: 1 = data memory word, 0 = register
//   address      debug word index
//   vout_addr    debug byte select within the word (0 = bits[7:0])
//   value_o      selected debug byte (combinational)
//   is_positive  selected word is signed > 0 (combinational)
//   easter_egg   [0] loaded, [1] halted, [2] illegal instruction seen
//
// Optional feature: define RV_BYTE_CPU_MUL_EN to enable MUL/MULH.
module rv_byte_cpu #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 32
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic [7:0] instr_i,
  input  logic       DataOrReg,
  input  logic [4:0] address,
  input  logic [1:0] vout_addr,
  output logic [7:0] value_o,
  output logic       is_positive,
  output logic [2:0] easter_egg
);
  localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
  localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);
  localparam int unsigned PC_W    = IMEM_AW + 2;
  localparam int unsigned WC_W    = IMEM_AW + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic [2:0]        egg_q, egg_d;
  logic [31:0]       regs_q [32];
  logic [31:0]       regs_d [32];
  logic [31:0]       dmem_q [DMEM_WORDS];
  logic [31:0]       dmem_d [DMEM_WORDS];
  logic [31:0]       imem_q [IMEM_WORDS];
  logic [31:0]       imem_d [IMEM_WORDS];

  logic [31:0]       ir, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]       rs1_val, rs2_val, mem_sum, rd_val, dbg_word;
  logic [6:0]        opcode, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [DMEM_AW-1:0] mem_idx;
  logic [PC_W-1:0]   pc_next;
  logic              rd_we, mem_we, illegal, take;

  // Shared ALU for OP and OP-IMM; alt selects SUB / SRA.
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    logic [31:0] r;
    r = '0;
    case (f3)
      3'b000: r = alt ? (a - b) : (a + b);
      3'b001: r = a << b[4:0];
      3'b010: r = {31'b0, ($signed(a) < $signed(b))};
      3'b011: r = {31'b0, (a < b)};
      3'b100: r = a ^ b;
      3'b101: r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Instruction fields and operands
  assign ir      = imem_q[pc_q[PC_W-1:2]];
  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign funct7  = ir[31:25];
  assign imm_i   = {{20{ir[31]}}, ir[31:20]};
  assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b   = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u   = {ir[31:12], 12'b0};
  assign imm_j   = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  assign mem_sum = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign mem_idx = DMEM_AW'(mem_sum >> 2);

`ifdef RV_BYTE_CPU_MUL_EN
  logic [63:0] prod;
  // Sign-extended 64-bit operands give the signed product in the low 64 bits.
  assign prod = {{32{rs1_val[31]}}, rs1_val} * {{32{rs2_val[31]}}, rs2_val};
`endif

  // Decode / execute
  always_comb begin
    illegal = 1'b0;
    rd_we   = 1'b0;
    rd_val  = '0;
    mem_we  = 1'b0;
    take    = 1'b0;
    pc_next = pc_q + PC_W'(4);
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = 32'(pc_q) + imm_u; end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_val  = 32'(pc_q) + 32'd4;
        pc_next = PC_W'(32'(pc_q) + imm_j);
      end
      OP_JALR: begin
        if (funct3 != 3'b000) illegal = 1'b1;
        else begin
          rd_we   = 1'b1;
          rd_val  = 32'(pc_q) + 32'd4;
          pc_next = PC_W'((rs1_val + imm_i) & ~32'd1);
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  take = (rs1_val == rs2_val);
          3'b001:  take = (rs1_val != rs2_val);
          3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
          3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  take = (rs1_val < rs2_val);
          3'b111:  take = (rs1_val >= rs2_val);
          default: illegal = 1'b1;
        endcase
        if (take) pc_next = PC_W'(32'(pc_q) + imm_b);
      end
      OP_LOAD: begin
        if (funct3 != 3'b010) illegal = 1'b1;
        else begin rd_we = 1'b1; rd_val = dmem_q[mem_idx]; end
      end
      OP_STORE: begin
        if (funct3 != 3'b010) illegal = 1'b1;
        else mem_we = 1'b1;
      end
      OP_IMM: begin
        if ((funct3 == 3'b001 && funct7 != 7'b0) ||
            (funct3 == 3'b101 && funct7 != 7'b0 && funct7 != 7'b0100000)) illegal = 1'b1;
        else begin
          rd_we  = 1'b1;
          rd_val = alu(rs1_val, imm_i, funct3, (funct3 == 3'b101) && funct7[5]);
        end
      end
      OP_REG: begin
        rd_we = 1'b1;
        if (funct7 == 7'b0) rd_val = alu(rs1_val, rs2_val, funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          rd_val = alu(rs1_val, rs2_val, funct3, 1'b1);
`ifdef RV_BYTE_CPU_MUL_EN
        else if (funct7 == 7'b0000001 && funct3 == 3'b000) rd_val = prod[31:0];
        else if (funct7 == 7'b0000001 && funct3 == 3'b001) rd_val = prod[63:32];
`endif
        else begin rd_we = 1'b0; illegal = 1'b1; end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Next-state: loader FSM and architectural state commit
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_buf_d = word_buf_q;
    egg_d      = egg_q;
    regs_d     = regs_q;
    dmem_d     = dmem_q;
    imem_d     = imem_q;
    case (state_q)
      S_IDLE: begin
        if (instr_i == 8'hFE) begin
          state_d    = S_LOAD;
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (byte_cnt_q == 2'd0 && instr_i == 8'hFF) begin
          egg_d[0] = 1'b1;
          state_d  = S_RUN;
        end else if (byte_cnt_q == 2'd0 && instr_i == 8'hFE) begin
          // Boundary start marker: not data, nothing to do.
        end else if (byte_cnt_q == 2'd3) begin
          imem_d[word_cnt_q[IMEM_AW-1:0]] = {instr_i, word_buf_q};
          word_cnt_d = word_cnt_q + WC_W'(1);
          byte_cnt_d = 2'd0;
          if (word_cnt_q == WC_W'(IMEM_WORDS - 1)) begin
            egg_d[0] = 1'b1;
            state_d  = S_RUN;
          end
        end else begin
          word_buf_d[{byte_cnt_q, 3'b000} +: 8] = instr_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      S_RUN: begin
        if ({1'b0, pc_q[PC_W-1:2]} >= word_cnt_q) begin
          egg_d[1] = 1'b1;
          state_d  = S_HALT;
        end else if (illegal) begin
          egg_d[2:1] = 2'b11;
          state_d    = S_HALT;
        end else begin
          pc_d = pc_next;
          if (rd_we && rd != 5'd0) regs_d[rd] = rd_val;
          if (mem_we) dmem_d[mem_idx] = rs2_val;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_buf_q <= '0;
      egg_q      <= '0;
      regs_q     <= '{default: '0};
      dmem_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_buf_q <= word_buf_d;
      egg_q      <= egg_d;
      regs_q     <= regs_d;
      dmem_q     <= dmem_d;
    end
  end

  // Instruction memory holds no reset; it is only read below word count.
  always_ff @(posedge clk_i) imem_q <= imem_d;

  // Debug read port
  always_comb begin
    if (DataOrReg)              dbg_word = dmem_q[DMEM_AW'(address)];
    else if (address == 5'd0)   dbg_word = '0;
    else                        dbg_word = regs_q[address];
  end

  assign value_o     = dbg_word[{vout_addr, 3'b000} +: 8];
  assign is_positive = ~dbg_word[31] & (|dbg_word);
  assign easter_egg  = egg_q;

endmodule

// File: tb/tb_rv_byte_cpu.sv
// Directed bench for rv_byte_cpu: streams programs byte-wise, waits for halt,
// and compares debug-port readback against a queue of expected values.
module tb_rv_byte_cpu;
  logic       clk_i = 1'b0;
  logic       reset;
  logic [7:0] instr_i;
  logic       DataOrReg;
  logic [4:0] address;
  logic [1:0] vout_addr;
  logic [7:0] value_o;
  logic       is_positive;
  logic [2:0] easter_egg;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] prog_q[$];

  localparam logic [6:0] OPI = 7'b0010011;

  always #5 clk_i = ~clk_i;

  rv_byte_cpu dut (
    .clk_i(clk_i), .reset(reset), .instr_i(instr_i), .DataOrReg(DataOrReg),
    .address(address), .vout_addr(vout_addr), .value_o(value_o),
    .is_positive(is_positive), .easter_egg(easter_egg)
  );

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, OPI);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    instr_i = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_i);
    #1;
    reset = 1'b0;
  endtask

  // Streams prog_q framed by 0xFE and (optionally) 0xFF, then clears the queue.
  task automatic load_prog(input bit send_end);
    logic [31:0] w;
    send_byte(8'hFE);
    while (prog_q.size() > 0) begin
      w = prog_q.pop_front();
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    end
    if (send_end) send_byte(8'hFF);
    instr_i = 8'h00;
  endtask

  task automatic wait_halt(input int budget);
    int c;
    c = 0;
    while (!easter_egg[1] && c < budget) begin
      @(posedge clk_i);
      #1;
      c++;
    end
    if (!easter_egg[1]) begin
      n_tests++;
      n_fail++;
      $display("FAIL halt_timeout: egg=%b after %0d cycles, required halted", easter_egg, c);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic compare(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", t, obs, e);
    end
  endtask

  task automatic read_word(input logic dor, input logic [4:0] a,
                           output logic [31:0] w, output logic pos);
    DataOrReg = dor;
    address   = a;
    for (int b = 0; b < 4; b++) begin
      vout_addr = 2'(b);
      #1;
      w[8*b +: 8] = value_o;
    end
    pos = is_positive;
  endtask

  task automatic chk_reg(input logic [4:0] r);
    logic [31:0] w; logic p;
    read_word(1'b0, r, w, p);
    compare(w);
  endtask
  task automatic chk_mem(input logic [4:0] a);
    logic [31:0] w; logic p;
    read_word(1'b1, a, w, p);
    compare(w);
  endtask
  task automatic chk_pos(input logic dor, input logic [4:0] a);
    logic [31:0] w; logic p;
    read_word(dor, a, w, p);
    compare({31'b0, p});
  endtask
  task automatic chk_egg();
    compare({29'b0, easter_egg});
  endtask

  initial begin
    reset = 1'b1; instr_i = 8'h00; DataOrReg = 1'b0; address = '0; vout_addr = '0;
    do_reset();

    // Reset state
    expect_val("rst_egg", 32'h0);        chk_egg();
    expect_val("rst_x1", 32'h0);         chk_reg(5'd1);
    expect_val("rst_pos", 32'h0);        chk_pos(1'b0, 5'd1);
    expect_val("rst_dmem0", 32'h0);      chk_mem(5'd0);

    // Single addi, garbage bytes before the start marker are ignored
    send_byte(8'h93); send_byte(8'h12);
    prog_q.push_back(addi(5'd1, 5'd0, 12'd5));
    expect_val("t1_egg", 32'h3);
    expect_val("t1_x1", 32'h5);
    expect_val("t1_pos", 32'h1);
    expect_val("t1_x0", 32'h0);
    load_prog(1'b1);
    wait_halt(3);
    chk_egg(); chk_reg(5'd1); chk_pos(1'b0, 5'd1); chk_reg(5'd0);

    // Mid-word 0xFF is data; boundary 0xFE between words is skipped
    do_reset();
    expect_val("t2_dmem2", 32'hFFFF_FFFF);
    expect_val("t2_pos", 32'h0);
    expect_val("t2_egg", 32'h3);
    expect_val("t2_x2", 32'hFFFF_FFFF);
    send_byte(8'hFE);
    begin
      logic [31:0] w0, w1;
      w0 = addi(5'd2, 5'd0, 12'hFFF);
      w1 = enc_s(12'd8, 5'd2, 5'd0);
      for (int b = 0; b < 4; b++) send_byte(w0[8*b +: 8]);
      send_byte(8'hFE);
      for (int b = 0; b < 4; b++) send_byte(w1[8*b +: 8]);
      send_byte(8'hFF);
      instr_i = 8'h00;
    end
    wait_halt(20);
    chk_mem(5'd2); chk_pos(1'b1, 5'd2); chk_egg(); chk_reg(5'd2);

    // Countdown loop with bne
    do_reset();
    prog_q.push_back(addi(5'd1, 5'd0, 12'd3));
    prog_q.push_back(addi(5'd1, 5'd1, 12'hFFF));
    prog_q.push_back(enc_b(12'hFFE, 5'd0, 5'd1, 3'b001));
    prog_q.push_back(addi(5'd3, 5'd0, 12'd7));
    expect_val("loop_x1", 32'h0);
    expect_val("loop_x3", 32'h7);
    expect_val("loop_egg", 32'h3);
    load_prog(1'b1);
    wait_halt(50);
    chk_reg(5'd1); chk_reg(5'd3); chk_egg();

    // ALU, memory, jump and branch mix
    do_reset();
    prog_q.push_back(addi(5'd1, 5'd0, 12'hFF8));                 //  0
    prog_q.push_back(addi(5'd2, 5'd0, 12'd3));                   //  4
    prog_q.push_back(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3)); //  8 sub
    prog_q.push_back(enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd4)); // 12 sra
    prog_q.push_back(enc_r(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd5)); // 16 srl
    prog_q.push_back(enc_r(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd6)); // 20 slt
    prog_q.push_back(enc_r(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd7)); // 24 sltu
    prog_q.push_back(enc_i(12'h0F0, 5'd2, 3'b100, 5'd8, OPI));   // 28 xori
    prog_q.push_back(enc_i(12'd4, 5'd2, 3'b001, 5'd9, OPI));     // 32 slli
    prog_q.push_back(enc_u(20'h12345, 5'd10, 7'b0110111));       // 36 lui
    prog_q.push_back(enc_u(20'h00001, 5'd11, 7'b0010111));       // 40 auipc
    prog_q.push_back(enc_s(12'd12, 5'd3, 5'd0));                 // 44 sw
    prog_q.push_back(enc_i(12'd13, 5'd0, 3'b010, 5'd12, 7'b0000011)); // 48 lw
    prog_q.push_back(enc_j(20'd4, 5'd13));                       // 52 jal +8
    prog_q.push_back(addi(5'd14, 5'd0, 12'd1));                  // 56 skipped
    prog_q.push_back(enc_b(12'd4, 5'd2, 5'd1, 3'b100));          // 60 blt +8
    prog_q.push_back(addi(5'd14, 5'd0, 12'd2));                  // 64 skipped
    prog_q.push_back(enc_b(12'd4, 5'd2, 5'd1, 3'b111));          // 68 bgeu +8
    prog_q.push_back(addi(5'd15, 5'd0, 12'd3));                  // 72 skipped
    prog_q.push_back(enc_i(12'd89, 5'd0, 3'b000, 5'd16, 7'b1100111)); // 76 jalr ->88
    prog_q.push_back(addi(5'd17, 5'd0, 12'd4));                  // 80 skipped
    prog_q.push_back(addi(5'd17, 5'd0, 12'd5));                  // 84 skipped
    prog_q.push_back(enc_r(7'b0000000, 5'd8, 5'd1, 3'b111, 5'd18)); // 88 and
    prog_q.push_back(addi(5'd0, 5'd0, 12'd5));                   // 92 x0 write
    expect_val("alu_sub", 32'hFFFF_FFF5);
    expect_val("alu_sra", 32'hFFFF_FFFF);
    expect_val("alu_srl", 32'h1FFF_FFFF);
    expect_val("alu_slt", 32'h1);
    expect_val("alu_sltu", 32'h0);
    expect_val("alu_xori", 32'h0000_00F3);
    expect_val("alu_slli", 32'h0000_0030);
    expect_val("alu_lui", 32'h1234_5000);
    expect_val("alu_auipc", 32'h0000_1028);
    expect_val("alu_dmem3", 32'hFFFF_FFF5);
    expect_val("alu_lw", 32'hFFFF_FFF5);
    expect_val("alu_jal_link", 32'd56);
    expect_val("alu_skip14", 32'h0);
    expect_val("alu_skip15", 32'h0);
    expect_val("alu_jalr_link", 32'd80);
    expect_val("alu_skip17", 32'h0);
    expect_val("alu_and", 32'h0000_00F0);
    expect_val("alu_x0", 32'h0);
    expect_val("alu_egg", 32'h3);
    load_prog(1'b1);
    wait_halt(100);
    chk_reg(5'd3); chk_reg(5'd4); chk_reg(5'd5); chk_reg(5'd6); chk_reg(5'd7);
    chk_reg(5'd8); chk_reg(5'd9); chk_reg(5'd10); chk_reg(5'd11); chk_mem(5'd3);
    chk_reg(5'd12); chk_reg(5'd13); chk_reg(5'd14); chk_reg(5'd15); chk_reg(5'd16);
    chk_reg(5'd17); chk_reg(5'd18); chk_reg(5'd0); chk_egg();

    // ECALL is illegal: halt with flag, next instruction never runs
    do_reset();
    prog_q.push_back(addi(5'd5, 5'd0, 12'd9));
    prog_q.push_back(32'h0000_0073);
    prog_q.push_back(addi(5'd6, 5'd0, 12'd1));
    expect_val("ecall_egg", 32'h7);
    expect_val("ecall_x5", 32'h9);
    expect_val("ecall_x6", 32'h0);
    load_prog(1'b1);
    wait_halt(30);
    chk_egg(); chk_reg(5'd5); chk_reg(5'd6);

    // Bytes in HALT are ignored
    prog_q.push_back(addi(5'd1, 5'd0, 12'd5));
    expect_val("halt_egg", 32'h7);
    expect_val("halt_x1", 32'h0);
    load_prog(1'b1);
    repeat (4) begin @(posedge clk_i); #1; end
    chk_egg(); chk_reg(5'd1);

    // Reset mid-LOAD aborts; only the new program runs
    do_reset();
    send_byte(8'hFE);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h01);
    do_reset();
    prog_q.push_back(addi(5'd4, 5'd0, 12'h012));
    prog_q.push_back(enc_s(12'd4, 5'd4, 5'd0));
    expect_val("abort_dmem1", 32'h12);
    expect_val("abort_dmem0", 32'h0);
    expect_val("abort_dmem2", 32'h0);
    expect_val("abort_x1", 32'h0);
    expect_val("abort_egg", 32'h3);
    load_prog(1'b1);
    wait_halt(30);
    chk_mem(5'd1); chk_mem(5'd0); chk_mem(5'd2); chk_reg(5'd1); chk_egg();

    // Full imem ends loading without 0xFF; last word (all zero) is illegal
    do_reset();
    for (int i = 0; i < 63; i++) prog_q.push_back(addi(5'd1, 5'd1, 12'd1));
    prog_q.push_back(32'h0000_0000);
    expect_val("full_egg", 32'h7);
    expect_val("full_x1", 32'd63);
    load_prog(1'b0);
    wait_halt(200);
    chk_egg(); chk_reg(5'd1);

    // MUL / MULH
    do_reset();
    prog_q.push_back(enc_u(20'h00010, 5'd1, 7'b0110111));
    prog_q.push_back(enc_u(20'h00010, 5'd2, 7'b0110111));
    prog_q.push_back(enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3));
    prog_q.push_back(enc_r(7'b0000001, 5'd2, 5'd1, 3'b001, 5'd4));
    prog_q.push_back(addi(5'd5, 5'd0, 12'd1));
    expect_val("mul_x1", 32'h0001_0000);
    expect_val("mul_x3", 32'h0);
`ifdef RV_BYTE_CPU_MUL_EN
    expect_val("mulh_x4", 32'h1);
    expect_val("mul_x5", 32'h1);
    expect_val("mul_egg", 32'h3);
`else
    expect_val("mulh_x4", 32'h0);
    expect_val("mul_x5", 32'h0);
    expect_val("mul_egg", 32'h7);
`endif
    load_prog(1'b1);
    wait_halt(30);
    chk_reg(5'd1); chk_reg(5'd3); chk_reg(5'd4); chk_reg(5'd5); chk_egg();

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rv_byte_cpu.md
Name: rv_byte_cpu

Overview:
- Small single-cycle RV32I-subset processor.
- The program is loaded one byte per clock over an 8-bit port, then executed from an internal 64-word instruction memory.
- Register file and data memory can be inspected byte-by-byte through a combinational debug port.
- Serves as the compute/demo core of the ALU test platform.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words (PC[7:2] index).
- DMEM_WORDS, 32, data memory depth in 32-bit words.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_i  input  8  program byte stream, one byte per cycle.
- DataOrReg  input  1  debug select: 1 = data memory word, 0 = register.
- address  input  5  debug word index (data word 0-31 or register x0-x31).
- vout_addr  input  2  debug byte select within the selected word; 0 = bits[7:0], 3 = bits[31:24].
- value_o  output  8  selected byte; combinational.
- is_positive  output  1  1 when the selected 32-bit word is signed > 0; combinational.
- easter_egg  output  3  status flags: [0] program loaded, [1] halted, [2] illegal instruction seen.

Behaviour:
- Reset (one clock with reset=1) does all of the following:
  - PC=0, word count=0, byte count=0, state=IDLE.
  - All registers and data memory are zeroed.
  - easter_egg=000.
  - value_o/is_positive then reflect zeroed storage, i.e. 0x00 and 0.
- States: IDLE -> LOAD -> RUN -> HALT.
- IDLE:
  - Ignores bytes until instr_i=0xFE; then goes to LOAD with byte count=0.
- LOAD:
  - Bytes assemble little-endian: first byte -> bits[7:0], fourth byte -> bits[31:24].
  - The word is written at the word-count index after the 4th byte; word count then increments.
  - 0xFF or 0xFE at a word boundary (byte count%4==0) is a marker, never data. These values are reserved RV32I opcodes, so there is no ambiguity.
  - 0xFF ends loading, sets easter_egg[0], and enters RUN the next cycle. A 0xFE at a boundary is ignored.
  - When word count reaches IMEM_WORDS, loading ends as if 0xFF had been received.
  - Mid-word markers are data.
- RUN:
  - One instruction per cycle: fetch imem[PC[7:2]], decode, execute, write back, update PC on the same edge.
  - Reaching PC[7:2] >= word count sets easter_egg[1] and enters HALT.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target LSB cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Illegal instruction (any other opcode/funct combination, including all-zero words):
  - Sets easter_egg[2] and [1], enters HALT, and performs no register, memory or PC write.
- Arithmetic rules:
  - 32-bit two's complement with wrap on overflow.
  - Shift amount = low 5 bits.
  - Immediates sign-extended per RV32I.
  - x0 always reads 0; writes to x0 are dropped.
- Memory:
  - LW/SW use word address (addr>>2) mod DMEM_WORDS; the low 2 bits are ignored (no misalign trap).
  - Branch/jump targets wrap modulo 256 bytes.
- HALT:
  - All state is frozen until reset; instr_i is ignored.
- Debug port:
  - Purely combinational from current storage.
  - When DataOrReg=0 and address=0, value_o reads 0.
- instr_i is ignored in RUN/HALT.
- Reset asserted mid-LOAD or mid-RUN aborts the operation and returns to IDLE with storage cleared.

Optional Feature:
- Macro RV_BYTE_CPU_MUL_EN.
- When defined: R-type funct7=0000001 with funct3=000 (MUL) writes the low 32 bits of rs1*rs2; funct3=001 (MULH) writes the high 32 bits of the signed product.
- When undefined: both encodings are illegal instructions (easter_egg[2] set, HALT).

Test Plan:
- Reset, then stream FE, 93 00 50 00 (addi x1,x0,5), FF -> easter_egg=011 within 3 cycles. Read back DataOrReg=0, address=1, vout_addr=0 -> value_o=0x05, is_positive=1.
- Stream FE, then addi x2,x0,-1 (bytes 13 01 F0 FF, FF mid-word is data), then sw x2,8(x0), then FF -> data word 2 bytes 0-3 = FF, is_positive=0, easter_egg=011.
- Branch loop: x1=3, loop addi x1,x1,-1 / bne x1,x0,-4, then addi x3,x0,7 -> x1=0, x3=0x07, halted.
- Load word 0x00000073 (ECALL, unsupported) -> easter_egg=111, no register changed, PC frozen.
- Assert reset for one cycle during LOAD after 6 bytes, then load a valid program -> only the new program runs; data memory reads 0x00 except words written by that program.
- With RV_BYTE_CPU_MUL_EN: x1=0x10000, x2=0x10000, MUL x3 -> x3=0, MULH x4 -> x4=0x00000001. Without the macro -> easter_egg[2]=1 at the MUL.
